acc_nibble_serial: RTL and testbench



---
 rtl/acc_nibble_serial.sv | 119 +++++++++++
 tb/tb_acc_nibble_serial.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/acc_nibble_serial.sv
// Nibble-serial unsigned accumulator: one 4-bit CLA slice per cycle folds an
// operand into an ACC_W-bit sum. The low APP_NIBBLES slices drop cin from their carry-out.
module acc_nibble_serial #(
  parameter int DATA_W      = 16,
  parameter int ACC_W       = 20,
  parameter int APP_NIBBLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_data
);
  localparam int NN = ACC_W / 4;
  localparam int KW = (NN > 1) ? $clog2(NN) : 1;

  typedef enum logic [1:0] {IDLE, ADD, HOLD} state_t;

  // Handshake: a transfer happens on a rising edge where valid & ready are both 1.
  // in_valid/out_ready may change freely; out_data is held stable while out_valid=1.
  state_t           state;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] op;
  logic [ACC_W-1:0] acc_nx;
  logic [KW-1:0]    k;
  logic             carry;
  logic             last_q;

  logic [3:0] a;
  logic [3:0] b;
  logic [3:0] p;
  logic [3:0] g;
  logic [3:0] c;
  logic [3:0] sum;
  logic       approx;
  logic       cout;
  logic       k_last;

  assign in_ready = rst_n & ~clr & (state == IDLE);

  always_comb begin
    a      = acc[4*k +: 4];
    b      = op[4*k +: 4];
    p      = a ^ b;
    g      = a & b;
    c[0]   = carry;
    c[1]   = g[0] | (p[0] & carry);
    c[2]   = g[1] | (p[1] & g[0]) | (p[1] & p[0] & carry);
    c[3]   = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & carry);
    sum    = p ^ c;
    approx = (int'(k) < APP_NIBBLES);
    // Approximate slices keep cin in their sum bits but not in the propagate-all carry term.
    cout   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
           | (~approx & (&p) & carry);
    acc_nx = acc;
    acc_nx[4*k +: 4] = sum;
    k_last = (int'(k) == NN - 1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      acc       <= '0;
      op        <= '0;
      k         <= '0;
      carry     <= 1'b0;
      last_q    <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (clr) begin
      state     <= IDLE;
      acc       <= '0;
      k         <= '0;
      carry     <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            op     <= ACC_W'(in_data);
            last_q <= in_last;
            k      <= '0;
            carry  <= 1'b0;
            state  <= ADD;
          end
        end
        ADD: begin
          acc   <= acc_nx;
          carry <= cout;
          k     <= k + 1'b1;
          if (k_last) begin
            // Final carry-out is dropped: the sum wraps modulo 2^ACC_W.
            k <= '0;
            if (last_q) begin
              out_valid <= 1'b1;
              out_data  <= acc_nx;
              state     <= HOLD;
            end else begin
              state <= IDLE;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            acc       <= '0;
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_acc_nibble_serial.sv
// Bench for acc_nibble_serial: an exact (APP_NIBBLES=0) and an approximate
// (APP_NIBBLES=2) instance share one stimulus stream; each has its own expected queue.
module tb_acc_nibble_serial;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        clr;
  logic        in_valid;
  logic [15:0] in_data;
  logic        in_last;
  logic        out_ready;

  logic        in_ready_e;
  logic        out_valid_e;
  logic [19:0] out_data_e;
  logic        in_ready_a;
  logic        out_valid_a;
  logic [19:0] out_data_a;

  logic [19:0] exp_e_q[$];
  logic [19:0] exp_a_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [15:0] op0;
    logic [15:0] op1;
    logic [19:0] exp_e;
    logic [19:0] exp_a;
  } vec_t;
  vec_t tbl[5];

  acc_nibble_serial #(.DATA_W(16), .ACC_W(20), .APP_NIBBLES(0)) u_exact (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(in_ready_e),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid_e),
    .out_ready(out_ready), .out_data(out_data_e)
  );

  acc_nibble_serial #(.DATA_W(16), .ACC_W(20), .APP_NIBBLES(2)) u_approx (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(in_ready_a),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid_a),
    .out_ready(out_ready), .out_data(out_data_a)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached (compared %0d)", n_cmp);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [19:0] act, input logic [19:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: per nibble, full 5-bit sum; approximate slices take carry from a+b alone.
  function automatic logic [19:0] model_add(input logic [19:0] acc, input logic [15:0] d,
                                            input int app);
    logic [19:0] bv;
    logic [19:0] r;
    logic [4:0]  s;
    logic [4:0]  sa;
    logic        c;
    bv = {4'h0, d};
    r  = '0;
    c  = 1'b0;
    for (int i = 0; i < 5; i++) begin
      s  = {1'b0, acc[4*i +: 4]} + {1'b0, bv[4*i +: 4]} + {4'b0, c};
      sa = {1'b0, acc[4*i +: 4]} + {1'b0, bv[4*i +: 4]};
      r[4*i +: 4] = s[3:0];
      c = (i < app) ? sa[4] : s[4];
    end
    return r;
  endfunction

  // scoreboard: pop on every observed output handshake
  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_ready === 1'b1) begin
      if (out_valid_e === 1'b1) begin
        if (exp_e_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL out_exact_unexpected: got %h expected no result", out_data_e);
        end else check("out_exact", out_data_e, exp_e_q.pop_front());
      end
      if (out_valid_a === 1'b1) begin
        if (exp_a_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL out_approx_unexpected: got %h expected no result", out_data_a);
        end else check("out_approx", out_data_a, exp_a_q.pop_front());
      end
    end
  end

  // driver: present one operand and hold it until accepted (bounded)
  task automatic accept(input logic [15:0] d, input logic last);
    int n;
    @(posedge clk); #1;
    in_valid = 1'b1; in_data = d; in_last = last;
    n = 0;
    @(negedge clk);
    while (!in_ready_e && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready_e) begin
      n_cmp++; n_bad++;
      $display("FAIL accept_timeout: got in_ready=0 expected 1 for operand %h", d);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic wait_out_valid();
    int n;
    n = 0;
    @(negedge clk);
    while (!out_valid_e && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid_e) begin
      n_cmp++; n_bad++;
      $display("FAIL wait_out_valid: got out_valid=0 expected 1 within 50 cycles");
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_e_q.size() != 0 || exp_a_q.size() != 0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (exp_e_q.size() != 0 || exp_a_q.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL drain: got %0d/%0d results outstanding expected 0/0",
               exp_e_q.size(), exp_a_q.size());
      exp_e_q.delete();
      exp_a_q.delete();
    end
  endtask

  initial begin
    int n;
    logic [19:0] me;
    logic [19:0] ma;
    int nops;
    logic [15:0] d;

    tbl[0] = '{16'hFFFF, 16'h0001, 20'h10000, 20'h0FF00};
    tbl[1] = '{16'h00F8, 16'h0008, 20'h00100, 20'h00000};
    tbl[2] = '{16'h1234, 16'h4321, 20'h05555, 20'h05555};
    tbl[3] = '{16'h0FFF, 16'h0001, 20'h01000, 20'h00F00};
    tbl[4] = '{16'hABCD, 16'h8765, 20'h13332, 20'h13332};

    rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_in_ready", 20'(in_ready_e), 20'd0);
    check("reset_out_valid", 20'(out_valid_e), 20'd0);
    check("reset_out_data_e", out_data_e, 20'h0);
    check("reset_out_data_a", out_data_a, 20'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_in_ready", 20'(in_ready_e), 20'd1);

    // first vector by hand with latency/throughput checks
    accept(tbl[0].op0, 1'b0);
    n = 0;
    @(negedge clk);
    while (!in_ready_e && n < 20) begin n++; @(negedge clk); end
    check("in_ready_low_cycles", 20'(n), 20'd5);
    exp_e_q.push_back(tbl[0].exp_e);
    exp_a_q.push_back(tbl[0].exp_a);
    accept(tbl[0].op1, 1'b1);
    n = 0;
    @(negedge clk);
    while (!out_valid_e && n < 20) begin n++; @(negedge clk); end
    check("out_valid_latency", 20'(n), 20'd5);
    drain();

    for (int i = 1; i < 5; i++) begin
      accept(tbl[i].op0, 1'b0);
      exp_e_q.push_back(tbl[i].exp_e);
      exp_a_q.push_back(tbl[i].exp_a);
      accept(tbl[i].op1, 1'b1);
      drain();
    end

    // wrap: 17 x 0xFFFF
    ma = '0;
    for (int i = 0; i < 17; i++) ma = model_add(ma, 16'hFFFF, 2);
    exp_e_q.push_back(20'h0FFEF);
    exp_a_q.push_back(ma);
    for (int i = 0; i < 17; i++) accept(16'hFFFF, (i == 16));
    drain();

    // backpressure in HOLD with a pending input
    out_ready = 1'b0;
    exp_e_q.push_back(20'h00001);
    exp_a_q.push_back(20'h00001);
    accept(16'h0001, 1'b1);
    wait_out_valid();
    @(posedge clk); #1;
    in_valid = 1'b1; in_data = 16'hBEEF; in_last = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("hold_out_valid", 20'(out_valid_e), 20'd1);
      check("hold_out_data", out_data_e, 20'h00001);
      check("hold_in_ready", 20'(in_ready_e), 20'd0);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
    drain();
    exp_e_q.push_back(20'h01234);
    exp_a_q.push_back(20'h01234);
    accept(16'h1234, 1'b1);
    drain();

    // clear during slice k=2 of 0x4321
    accept(16'h4321, 1'b1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    clr = 1'b1;
    @(negedge clk);
    check("clr_in_ready", 20'(in_ready_e), 20'd0);
    @(posedge clk); #1;
    clr = 1'b0;
    @(negedge clk);
    check("after_clr_out_valid", 20'(out_valid_e), 20'd0);
    check("after_clr_in_ready", 20'(in_ready_e), 20'd1);
    exp_e_q.push_back(20'h00007);
    exp_a_q.push_back(20'h00007);
    accept(16'h0007, 1'b1);
    drain();

    // reset while holding a result
    out_ready = 1'b0;
    accept(16'h0055, 1'b1);
    wait_out_valid();
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_hold_out_valid", 20'(out_valid_e), 20'd0);
    check("rst_hold_out_data_e", out_data_e, 20'h0);
    check("rst_hold_out_data_a", out_data_a, 20'h0);
    out_ready = 1'b1;

    // clr with in_valid in IDLE must not accept
    @(posedge clk); #1;
    clr = 1'b1; in_valid = 1'b1; in_data = 16'h0033; in_last = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("clr_valid_in_ready", 20'(in_ready_e), 20'd0);
    end
    @(posedge clk); #1;
    clr = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    exp_e_q.push_back(20'h00002);
    exp_a_q.push_back(20'h00002);
    accept(16'h0002, 1'b1);
    drain();

    // random groups against the reference model
    for (int gidx = 0; gidx < 12; gidx++) begin
      nops = $urandom_range(1, 4);
      me = '0;
      ma = '0;
      for (int j = 0; j < nops; j++) begin
        d  = 16'($urandom_range(0, 16'hFFFF));
        me = model_add(me, d, 0);
        ma = model_add(ma, d, 2);
        if (j == nops - 1) begin
          exp_e_q.push_back(me);
          exp_a_q.push_back(ma);
        end
        accept(d, (j == nops - 1));
      end
      drain();
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end

    repeat (5) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
